// File: rtl/crtc_pkg.sv
// Shared types and default timing for the CRTC timing generator.
// The shadowed per-frame timing set is carried as a single packed struct.
package crtc_pkg;

  localparam int CRTC_HW = 8;
  localparam int CRTC_VW = 10;

  typedef struct packed {
    logic [CRTC_HW-1:0] htotal;
    logic [CRTC_HW-1:0] hsync_end;
    logic [CRTC_HW-1:0] hdisp_start;
    logic [CRTC_HW-1:0] hdisp_end;
    logic [CRTC_VW-1:0] vtotal;
    logic [CRTC_VW-1:0] vsync_end;
    logic [CRTC_VW-1:0] vdisp_start;
    logic [CRTC_VW-1:0] vdisp_end;
    logic [CRTC_VW-1:0] raster_line;
    logic               interlace;
    logic               doublescan;
  } crtc_timing_t;

  // 31 kHz line rate, 64x8 = 512 visible dots by 512 visible lines.
  localparam crtc_timing_t CRTC_TIMING_512X512 = '{
    htotal:      8'd83,
    hsync_end:   8'd8,
    hdisp_start: 8'd14,
    hdisp_end:   8'd78,
    vtotal:      10'd564,
    vsync_end:   10'd6,
    vdisp_start: 10'd40,
    vdisp_end:   10'd552,
    raster_line: 10'd0,
    interlace:   1'b0,
    doublescan:  1'b0
  };

endpackage

// File: rtl/crtc_phase_acc.sv
// Fractional dot-clock enable: emits a one-gclk pix_ce each time the
// accumulated phase passes the modulus (every gclk when the modulus is zero).
module crtc_phase_acc #(
  parameter int AW = 20
) (
  input  logic          gclk,
  input  logic          rstn,
  input  logic [AW-1:0] i_acc_inc,
  input  logic [AW-1:0] i_acc_mod,
  output logic          o_pix_ce
);

  logic [AW-1:0] r_acc;
  logic          r_pix_ce;
  logic [AW:0]   w_sum;
  logic [AW-1:0] w_wrap;
  logic          w_hit;

  always_comb begin
    w_sum  = {1'b0, r_acc} + {1'b0, i_acc_inc};
    w_hit  = (w_sum >= {1'b0, i_acc_mod});
    w_wrap = w_sum[AW-1:0] - i_acc_mod;
  end

  // NOTE: state registers use non-blocking assignments so every register in
  // the design samples pre-edge values regardless of statement order.
  always_ff @(posedge gclk) begin
    if (!rstn) begin
      r_acc    <= '0;
      r_pix_ce <= 1'b0;
    end else begin
      r_pix_ce <= w_hit;
      r_acc    <= w_hit ? w_wrap : w_sum[AW-1:0];
    end
  end

  assign o_pix_ce = r_pix_ce;

endmodule

// File: rtl/crtc_timing_gen.sv
// CRTC raster timing: dot/character/line counters, sync/blank/de flags,
// line-buffer addressing and raster interrupt, all advancing on pix_ce.
module crtc_timing_gen
  import crtc_pkg::*;
#(
  parameter int HW   = CRTC_HW,
  parameter int VW   = CRTC_VW,
  parameter int AW   = 20,
  parameter int DOTS = 8,
  parameter int LW   = 10
) (
  input  logic          gclk,
  input  logic          rstn,
  input  logic [AW-1:0] i_acc_inc,
  input  logic [AW-1:0] i_acc_mod,
  input  logic          i_interlace,
  input  logic          i_doublescan,
  input  logic [HW-1:0] i_htotal,
  input  logic [HW-1:0] i_hsync_end,
  input  logic [HW-1:0] i_hdisp_start,
  input  logic [HW-1:0] i_hdisp_end,
  input  logic [VW-1:0] i_vtotal,
  input  logic [VW-1:0] i_vsync_end,
  input  logic [VW-1:0] i_vdisp_start,
  input  logic [VW-1:0] i_vdisp_end,
  input  logic [VW-1:0] i_raster_line,
  output logic          o_pix_ce,
  output logic [HW-1:0] o_hcount,
  output logic [VW-1:0] o_vcount,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_hblank,
  output logic          o_vblank,
  output logic          o_de,
  output logic          o_hcomp,
  output logic          o_vcomp,
  output logic          o_field,
  output logic          o_raster_irq,
  output logic          o_line_sel,
  output logic [LW-1:0] o_line_addr
);

  localparam int DW = (DOTS > 1) ? $clog2(DOTS) : 1;
  localparam logic [DW-1:0] DOT_LAST = DW'(DOTS - 1);

  crtc_timing_t  w_live, r_tim, w_tim_nx;
  logic [DW-1:0] r_dot;
  logic [HW-1:0] r_hcount, w_hcount_nx;
  logic [VW-1:0] r_vcount, w_vcount_nx;
  logic [VW:0]   w_vlast;
  logic          r_rep, r_field, r_line_sel;
  logic          r_hsync, r_vsync, r_hblank, r_vblank, r_de;
  logic [LW-1:0] r_line_addr;
  logic          w_pix_ce, w_dot_last, w_hcomp, w_vcomp, w_v_adv, w_irq;
  logic          w_hblank_nx, w_vblank_nx;

  crtc_phase_acc #(.AW(AW)) u_phase_acc (
    .gclk      (gclk),
    .rstn      (rstn),
    .i_acc_inc (i_acc_inc),
    .i_acc_mod (i_acc_mod),
    .o_pix_ce  (w_pix_ce)
  );

  assign w_live = '{
    htotal:      i_htotal,
    hsync_end:   i_hsync_end,
    hdisp_start: i_hdisp_start,
    hdisp_end:   i_hdisp_end,
    vtotal:      i_vtotal,
    vsync_end:   i_vsync_end,
    vdisp_start: i_vdisp_start,
    vdisp_end:   i_vdisp_end,
    raster_line: i_raster_line,
    interlace:   i_interlace,
    doublescan:  i_doublescan
  };

  // NOTE: every always_comb output gets a default before any branch, so no
  // path can leave a value unassigned and infer a latch.
  always_comb begin
    w_vlast    = {1'b0, r_tim.vtotal} + (VW+1)'(r_tim.interlace & r_field);
    w_dot_last = (r_dot == DOT_LAST);
    w_hcomp    = w_pix_ce & w_dot_last & (r_hcount == r_tim.htotal);
    w_v_adv    = ~r_tim.doublescan | r_rep;
    w_vcomp    = w_hcomp & w_v_adv & ({1'b0, r_vcount} == w_vlast);
    // The frame boundary hands the fresh inputs to the first position of the
    // next frame, so flags there already reflect the new timing.
    w_tim_nx   = w_vcomp ? w_live : r_tim;

    w_hcount_nx = r_hcount;
    if (w_hcomp)
      w_hcount_nx = '0;
    else if (w_pix_ce && w_dot_last)
      w_hcount_nx = r_hcount + HW'(1);

    w_vcount_nx = r_vcount;
    if (w_vcomp)
      w_vcount_nx = '0;
    else if (w_hcomp && w_v_adv)
      w_vcount_nx = r_vcount + VW'(1);

    w_irq       = w_hcomp & w_v_adv & (w_vcount_nx == w_tim_nx.raster_line);
    w_hblank_nx = ~((w_hcount_nx >= w_tim_nx.hdisp_start) &&
                    (w_hcount_nx <  w_tim_nx.hdisp_end));
    w_vblank_nx = ~((w_vcount_nx >= w_tim_nx.vdisp_start) &&
                    (w_vcount_nx <  w_tim_nx.vdisp_end));
  end

  always_ff @(posedge gclk) begin
    if (!rstn) begin
      r_tim       <= w_live;
      r_dot       <= '0;
      r_hcount    <= '0;
      r_vcount    <= '0;
      r_rep       <= 1'b0;
      r_field     <= 1'b0;
      r_line_sel  <= 1'b1;
      r_hsync     <= 1'b0;
      r_vsync     <= 1'b0;
      r_hblank    <= 1'b1;
      r_vblank    <= 1'b1;
      r_de        <= 1'b0;
      r_line_addr <= '0;
    end else begin
      r_tim <= w_tim_nx;
      if (w_pix_ce) begin
        r_dot    <= w_dot_last ? '0 : r_dot + DW'(1);
        r_hcount <= w_hcount_nx;
        r_vcount <= w_vcount_nx;
        r_hsync  <= (w_hcount_nx < w_tim_nx.hsync_end);
        r_vsync  <= (w_vcount_nx < w_tim_nx.vsync_end);
        r_hblank <= w_hblank_nx;
        r_vblank <= w_vblank_nx;
        r_de     <= ~w_hblank_nx & ~w_vblank_nx;
      end
      if (w_hcomp) begin
        r_line_sel <= ~r_line_sel;
        // Second pass of a doubled line clears the bit and lets vcount move.
        r_rep      <= r_tim.doublescan & ~r_rep;
      end
      if (w_vcomp)
        r_field <= w_live.interlace & ~r_field;
      if (w_hcomp)
        r_line_addr <= '0;
      else if (w_pix_ce && r_de && !(&r_line_addr))
        r_line_addr <= r_line_addr + LW'(1);
    end
  end

  assign o_pix_ce     = w_pix_ce;
  assign o_hcount     = r_hcount;
  assign o_vcount     = r_vcount;
  assign o_hsync      = r_hsync;
  assign o_vsync      = r_vsync;
  assign o_hblank     = r_hblank;
  assign o_vblank     = r_vblank;
  assign o_de         = r_de;
  assign o_hcomp      = w_hcomp;
  assign o_vcomp      = w_vcomp;
  assign o_field      = r_field;
  assign o_raster_irq = w_irq;
  assign o_line_sel   = r_line_sel;
  assign o_line_addr  = r_line_addr;

endmodule

// File: tb/tb_crtc_timing_gen.sv
// Directed bench for crtc_timing_gen: small 8-dot, 4-char raster with
// hand-computed positions, plus interlace, doublescan, reset and phase cases.
module tb_crtc_timing_gen;

  localparam int HW = 8, VW = 10, AW = 20, DOTS = 8, LW = 10;

  logic          gclk = 1'b0;
  logic          rstn = 1'b0;
  logic [AW-1:0] acc_inc = 20'd1, acc_mod = 20'd0;
  logic          interlace = 1'b0, doublescan = 1'b0;
  logic [HW-1:0] htotal = 8'd3, hsync_end = 8'd1, hdisp_start = 8'd1, hdisp_end = 8'd3;
  logic [VW-1:0] vtotal = 10'd2, vsync_end = 10'd1, vdisp_start = 10'd0, vdisp_end = 10'd2;
  logic [VW-1:0] raster_line = 10'd1;

  logic          pix_ce, hsync, vsync, hblank, vblank, de;
  logic          hcomp, vcomp, field, raster_irq, line_sel;
  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  logic [LW-1:0] line_addr;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 gclk = ~gclk;

  crtc_timing_gen #(.HW(HW), .VW(VW), .AW(AW), .DOTS(DOTS), .LW(LW)) dut (
    .gclk(gclk), .rstn(rstn),
    .i_acc_inc(acc_inc), .i_acc_mod(acc_mod),
    .i_interlace(interlace), .i_doublescan(doublescan),
    .i_htotal(htotal), .i_hsync_end(hsync_end),
    .i_hdisp_start(hdisp_start), .i_hdisp_end(hdisp_end),
    .i_vtotal(vtotal), .i_vsync_end(vsync_end),
    .i_vdisp_start(vdisp_start), .i_vdisp_end(vdisp_end),
    .i_raster_line(raster_line),
    .o_pix_ce(pix_ce), .o_hcount(hcount), .o_vcount(vcount),
    .o_hsync(hsync), .o_vsync(vsync), .o_hblank(hblank), .o_vblank(vblank),
    .o_de(de), .o_hcomp(hcomp), .o_vcomp(vcomp), .o_field(field),
    .o_raster_irq(raster_irq), .o_line_sel(line_sel), .o_line_addr(line_addr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge gclk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  // After this, the sample in cycle 0 is the first pix_ce, at dot 0 of line 0.
  task automatic release_rst();
    rstn = 1'b1;
    cyc  = -1;
    tick();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".pix_ce"},    pix_ce,    0);
    check({tag, ".hcomp"},     hcomp,     0);
    check({tag, ".vcomp"},     vcomp,     0);
    check({tag, ".irq"},       raster_irq, 0);
    check({tag, ".hsync"},     hsync,     0);
    check({tag, ".vsync"},     vsync,     0);
    check({tag, ".de"},        de,        0);
    check({tag, ".hblank"},    hblank,    1);
    check({tag, ".vblank"},    vblank,    1);
    check({tag, ".line_sel"},  line_sel,  1);
    check({tag, ".hcount"},    hcount,    0);
    check({tag, ".vcount"},    vcount,    0);
    check({tag, ".line_addr"}, line_addr, 0);
    check({tag, ".field"},     field,     0);
  endtask

  initial begin
    int n_h, n_v, n_de, n_ce, n_irq, n_sel, n_pair, max_addr;
    logic prev;

    // ---- reset state, 8 dots x 4 chars x 3 lines, every gclk a dot ----
    tick(); tick();
    check_reset_state("rst");
    release_rst();
    check("c0.pix_ce", pix_ce, 1);
    check("c0.hcount", hcount, 0);
    check("c0.de", de, 0);
    run_to(1);
    check("c1.hsync", hsync, 1);
    check("c1.vsync", vsync, 1);
    check("c1.hblank", hblank, 1);
    check("c1.vblank", vblank, 0);
    run_to(8);
    check("c8.hcount", hcount, 1);
    check("c8.hsync", hsync, 0);
    check("c8.de", de, 1);
    check("c8.line_addr", line_addr, 0);
    run_to(23);
    check("c23.de", de, 1);
    check("c23.line_addr", line_addr, 15);
    run_to(24);
    check("c24.hcount", hcount, 3);
    check("c24.de", de, 0);
    check("c24.hblank", hblank, 1);
    check("c24.line_addr", line_addr, 16);
    run_to(31);
    check("c31.hcomp", hcomp, 1);
    check("c31.vcomp", vcomp, 0);
    check("c31.irq", raster_irq, 1);
    check("c31.line_sel", line_sel, 1);
    run_to(32);
    check("c32.hcomp", hcomp, 0);
    check("c32.vcount", vcount, 1);
    check("c32.line_sel", line_sel, 0);
    check("c32.line_addr", line_addr, 0);
    check("c32.vsync", vsync, 0);
    run_to(63);
    check("c63.hcomp", hcomp, 1);
    check("c63.irq", raster_irq, 0);
    run_to(64);
    check("c64.vcount", vcount, 2);
    check("c64.vblank", vblank, 1);
    run_to(95);
    check("c95.vcomp", vcomp, 1);
    run_to(96);
    check("c96.vcount", vcount, 0);
    check("c96.hcount", hcount, 0);

    // two full frames: 6 lines, 2 frames, 4 displayed lines of 16 dots
    n_h = 0; n_v = 0; n_de = 0; n_ce = 0; max_addr = 0;
    for (int i = 0; i < 192; i++) begin
      if (i > 0) tick();
      n_h  += int'(hcomp);
      n_v  += int'(vcomp);
      n_de += int'(de);
      n_ce += int'(pix_ce);
      if (de && int'(line_addr) > max_addr) max_addr = int'(line_addr);
    end
    check("frames.hcomp", n_h, 6);
    check("frames.vcomp", n_v, 2);
    check("frames.de", n_de, 64);
    check("frames.pix_ce", n_ce, 192);
    check("frames.max_addr", max_addr, 15);

    // ---- htotal 3 -> 5 mid-frame: takes effect only after vcomp ----
    run_to(300);
    htotal = 8'd5;
    run_to(319);
    check("ht.c319.hcomp", hcomp, 1);
    run_to(351);
    check("ht.c351.hcomp", hcomp, 1);
    run_to(383);
    check("ht.c383.vcomp", vcomp, 1);
    run_to(415);
    check("ht.c415.hcomp", hcomp, 0);
    run_to(420);
    check("ht.c420.hcount", hcount, 4);
    run_to(431);
    check("ht.c431.hcomp", hcomp, 1);
    run_to(527);
    check("ht.c527.vcomp", vcomp, 1);

    // ---- one-gclk reset mid-line while de is high ----
    run_to(540);
    check("mid.de", de, 1);
    check("mid.line_addr", line_addr, 4);
    rstn = 1'b0;
    htotal = 8'd3;
    tick();
    check_reset_state("midrst");
    release_rst();
    check("rr.c0.pix_ce", pix_ce, 1);
    check("rr.c0.hcount", hcount, 0);
    check("rr.c0.vcount", vcount, 0);
    run_to(8);
    check("rr.c8.hcount", hcount, 1);
    run_to(31);
    check("rr.c31.hcomp", hcomp, 1);

    // ---- interlace, vtotal=4: 5-line then 6-line frames ----
    rstn = 1'b0;
    interlace = 1'b1;
    vtotal = 10'd4;
    tick(); tick();
    release_rst();
    run_to(127);
    check("il.c127.hcomp", hcomp, 1);
    check("il.c127.vcomp", vcomp, 0);
    run_to(159);
    check("il.c159.vcomp", vcomp, 1);
    check("il.c159.field", field, 0);
    run_to(160);
    check("il.c160.field", field, 1);
    check("il.c160.vcount", vcount, 0);
    run_to(300);
    check("il.c300.vcount", vcount, 4);
    run_to(319);
    check("il.c319.vcomp", vcomp, 0);
    run_to(320);
    check("il.c320.vcount", vcount, 5);
    run_to(351);
    check("il.c351.vcomp", vcomp, 1);
    run_to(352);
    check("il.c352.field", field, 0);
    run_to(479);
    check("il.c479.vcomp", vcomp, 0);
    run_to(511);
    check("il.c511.vcomp", vcomp, 1);

    // ---- doublescan, vtotal=2, raster_line=1: 6 physical lines per frame ----
    rstn = 1'b0;
    interlace = 1'b0;
    vtotal = 10'd2;
    doublescan = 1'b1;
    tick(); tick();
    release_rst();
    run_to(40);
    check("ds.c40.vcount", vcount, 0);
    check("ds.c40.line_sel", line_sel, 0);
    run_to(63);
    check("ds.c63.irq", raster_irq, 1);
    run_to(64);
    check("ds.c64.vcount", vcount, 1);
    check("ds.c64.line_sel", line_sel, 1);
    run_to(95);
    check("ds.c95.hcomp", hcomp, 1);
    check("ds.c95.irq", raster_irq, 0);
    run_to(100);
    check("ds.c100.vcount", vcount, 1);
    run_to(128);
    check("ds.c128.vcount", vcount, 2);
    run_to(191);
    check("ds.c191.vcomp", vcomp, 1);
    n_h = 0; n_v = 0; n_irq = 0; n_sel = 0;
    prev = line_sel;
    for (int i = 0; i < 192; i++) begin
      tick();
      n_h   += int'(hcomp);
      n_v   += int'(vcomp);
      n_irq += int'(raster_irq);
      n_sel += int'(line_sel != prev);
      prev = line_sel;
    end
    check("ds.frame.hcomp", n_h, 6);
    check("ds.frame.vcomp", n_v, 1);
    check("ds.frame.irq", n_irq, 1);
    check("ds.frame.line_sel", n_sel, 6);

    // ---- fractional phase: 12500 / 43133 ----
    rstn = 1'b0;
    doublescan = 1'b0;
    acc_inc = 20'd12500;
    acc_mod = 20'd43133;
    tick(); tick();
    release_rst();
    n_ce = 0; n_pair = 0;
    prev = 1'b0;
    for (int i = 0; i < 43133; i++) begin
      if (i > 0) tick();
      n_ce += int'(pix_ce);
      if (pix_ce && prev) n_pair++;
      prev = pix_ce;
    end
    check("phase.in_range", (n_ce >= 12499 && n_ce <= 12501), 1);
    check("phase.back_to_back", n_pair, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
